// File: rtl/clock_pkg.sv
// Shared definitions for the board's quarter-second up/down counters:
// the countdown state type, the tick period constant and a counter-width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Clock cycles per quarter second at 125 MHz.
  localparam int TICK_QUARTER_SEC = 31250000;

  // A counter for n states needs clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_countdown_if.sv
// Control and status bundle of the countdown.
// Handshake: load is a single-cycle strobe that is always accepted (there is no ready);
// load_val is sampled only on that cycle. The outputs are all registered.
interface clock_countdown_if
  import clock_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             paused;
  logic             done;
  state_t           state;

  modport master (
    output en, load, load_val,
    input  out, busy, paused, done, state
  );

  modport slave (
    input  en, load, load_val,
    output out, busy, paused, done, state
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: issues a one-cycle tick every TICK_CYCLES enabled cycles.
// clr restarts the period and takes priority over en.
module tick_prescaler
  import clock_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_QUARTER_SEC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = cnt_width(TICK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] cnt;

  // The tick fires in the same cycle the counter wraps.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/clock_countdown.sv
// Loadable down-counter: decrements once per prescaled tick while enabled and
// pulses done for one cycle when the count reaches zero.
module clock_countdown
  import clock_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_QUARTER_SEC,
  parameter int WIDTH       = 4
) (
  input logic              clk,
  input logic              rst,
  clock_countdown_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_q, out_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, paused_q;
  logic             pre_en, pre_clr, tick;

  // The prescaler only runs while a countdown is active; IDLE ignores en.
  assign pre_en = bus.en && (state != IDLE);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_q    <= out_nxt;
      done_q   <= done_nxt;
      busy_q   <= (state_nxt != IDLE);
      paused_q <= (state_nxt == PAUSE);
    end
  end

  always_comb begin
    state_nxt = state;
    out_nxt   = out_q;
    done_nxt  = 1'b0;
    pre_clr   = 1'b0;

    if (bus.load) begin
      // A load overrides any tick in the same cycle.
      out_nxt = bus.load_val;
      pre_clr = 1'b1;
      if (bus.load_val != '0) begin
        state_nxt = bus.en ? RUN : PAUSE;
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end else begin
      unique case (state)
        RUN, PAUSE: begin
          state_nxt = bus.en ? RUN : PAUSE;
          if (tick) begin
            out_nxt = out_q - WIDTH'(1);
            if (out_q == WIDTH'(1)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
              pre_clr   = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.paused = paused_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_clock_countdown.sv
// Directed and randomized checks of clock_countdown against a cycle-level
// reference model of the countdown rules.
module tb_clock_countdown;
  import clock_pkg::*;

  localparam int TICK = 4;
  localparam int W    = 4;

  logic clk;
  logic rst;

  clock_countdown_if #(.WIDTH(W)) bus ();

  clock_countdown #(
    .TICK_CYCLES(TICK),
    .WIDTH      (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int m_out;
  int m_phase;
  bit m_active;
  bit m_paused;
  bit m_done;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One clock edge of the countdown rules, applied to the inputs seen at that edge.
  task automatic model_edge(input bit r, input bit e, input bit l, input int lv);
    if (r) begin
      m_out = 0; m_phase = 0; m_active = 0; m_paused = 0; m_done = 0;
    end else if (l) begin
      m_out    = lv;
      m_phase  = 0;
      m_active = (lv != 0);
      m_done   = (lv == 0);
      m_paused = m_active && !e;
    end else if (m_active) begin
      m_done = 0;
      if (e) begin
        m_phase++;
        if (m_phase == TICK) begin
          m_phase = 0;
          m_out--;
          if (m_out == 0) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
      m_paused = m_active && !e;
    end else begin
      m_done = 0;
    end
  endtask

  // Driver: apply inputs, take one edge, then compare all outputs with the model.
  task automatic step(input bit r, input bit e, input bit l, input int lv);
    rst          = r;
    bus.en       = e;
    bus.load     = l;
    bus.load_val = W'(lv);
    @(posedge clk);
    model_edge(r, e, l, lv);
    #1;
    check("out",    32'(bus.out),    32'(m_out));
    check("busy",   32'(bus.busy),   32'(m_active));
    check("paused", 32'(bus.paused), 32'(m_paused));
    check("done",   32'(bus.done),   32'(m_done));
  endtask

  // Run with en high until done, bounded; check the total edges since the load.
  task automatic run_until_done(input string tag, input int already, input int exp_total);
    int cyc = already;
    do begin
      step(0, 1, 0, 0);
      cyc++;
    end while (bus.done !== 1'b1 && cyc < already + 200);
    check(tag, 32'(cyc), 32'(exp_total));
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_out",   32'(bus.out),  32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));
    step(0, 1, 0, 0);

    // Load 3: decrements every 4 cycles, done after 12
    step(0, 1, 1, 3);
    check("load3_out", 32'(bus.out), 32'd3);
    run_until_done("load3_time", 0, 12);
    check("load3_end_out", 32'(bus.out), 32'd0);
    step(0, 1, 0, 0);

    // Load 0: immediate done pulse, never busy
    step(0, 1, 1, 0);
    check("load0_done", 32'(bus.done), 32'd1);
    step(0, 1, 0, 0);
    check("load0_done_once", 32'(bus.done), 32'd0);

    // Load 2 with a 5-cycle en drop at cycle 2
    step(0, 1, 1, 2);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("pause_flag", 32'(bus.paused), 32'd1);
    check("pause_state", 32'(bus.state), 32'(PAUSE));
    run_until_done("pause_total", 7, 13);

    // Load 5, reload 9 on the third tick edge: tick discarded, no done
    step(0, 1, 1, 5);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 9);
    check("reload_out",  32'(bus.out),  32'd9);
    check("reload_done", 32'(bus.done), 32'd0);
    run_until_done("reload_time", 0, 36);

    // Reset in the middle of a countdown from 7
    step(0, 1, 1, 7);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("midrst_out",  32'(bus.out),  32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 4);
    run_until_done("after_rst_time", 0, 16);

    // Full-scale countdown, then IDLE holds 0
    step(0, 1, 1, 15);
    run_until_done("load15_time", 0, 60);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    check("idle_hold", 32'(bus.out), 32'd0);

    // Randomized en/load/rst traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
